// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low segment decoder.
// Non-decimal nibbles render as a dash; the blank flag overrides everything.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Latches packed BCD on bcd_vld and scans it onto a 4-digit common-anode display,
// committing new values only at frame boundaries. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_sevenseg_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic        bcd_vld,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD_CYCLES);

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [1:0]      idx_reg, idx_next;
    logic [15:0]     disp_reg, disp_next;
    logic [15:0]     shadow_reg, shadow_next;
    logic            pending_reg, pending_next;
    logic [3:0]      an_reg, an_next;
    logic [6:0]      seg_reg, seg_next;
    logic            frame_tick_reg, frame_tick_next;

    logic            frame_end;
    logic [3:0]      cur_nibble;
    logic            cur_blank;
    logic [6:0]      dec_seg;

    assign frame_end = (state_reg == SCAN) && (presc_reg == PRESC_LAST) && (idx_reg == 2'd3);
    assign cur_nibble = disp_reg[idx_reg*4 +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[k]: digit k and everything above it are zero
    logic [NUM_DIGITS-1:0] upper_zero;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
            assign upper_zero[gi] = (disp_reg[15:4*gi] == '0);
        end
    endgenerate
    assign cur_blank = (idx_reg != 2'd0) && upper_zero[idx_reg];
`else
    assign cur_blank = 1'b0;
`endif

    bcd_to_seg u_dec (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .seg    (dec_seg)
    );

    always_comb begin
        state_next   = state_reg;
        presc_next   = presc_reg;
        idx_next     = idx_reg;
        disp_next    = disp_reg;
        shadow_next  = shadow_reg;
        pending_next = pending_reg;
        case (state_reg)
            BLANK: begin
                presc_next = '0;
                idx_next   = 2'd0;
                if (bcd_vld) begin
                    disp_next  = bcd_in;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (presc_reg == PRESC_LAST) begin
                    presc_next = '0;
                    idx_next   = idx_reg + 2'd1;
                end else begin
                    presc_next = presc_reg + 1'b1;
                end
                // a strobe landing on the frame edge bypasses the shadow entirely
                if (frame_end) begin
                    if (bcd_vld) begin
                        disp_next    = bcd_in;
                        pending_next = 1'b0;
                    end else if (pending_reg) begin
                        disp_next    = shadow_reg;
                        pending_next = 1'b0;
                    end
                end else if (bcd_vld) begin
                    shadow_next  = bcd_in;
                    pending_next = 1'b1;
                end
            end
            default: begin
                state_next = BLANK;
                presc_next = '0;
                idx_next   = 2'd0;
            end
        endcase
    end

    always_comb begin
        an_next  = 4'b1111;
        seg_next = SEG_BLANK;
        if (state_reg == SCAN && presc_reg >= GUARD_END) begin
            an_next  = ~(4'b0001 << idx_reg);
            seg_next = dec_seg;
        end
        frame_tick_next = (state_next == SCAN) && (presc_next == PRESC_LAST) && (idx_next == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= BLANK;
            presc_reg      <= '0;
            idx_reg        <= 2'd0;
            disp_reg       <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            an_reg         <= 4'b1111;
            seg_reg        <= SEG_BLANK;
            frame_tick_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            presc_reg      <= presc_next;
            idx_reg        <= idx_next;
            disp_reg       <= disp_next;
            shadow_reg     <= shadow_next;
            pending_reg    <= pending_next;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = 1'b1;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Self-checking bench for bcd_sevenseg_scan (REFRESH_DIV=8, GUARD_CYCLES=2) with a
// cycle-counting reference model plus frame-capture table checks.
module tb_bcd_sevenseg_scan;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        bcd_vld = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // reference model: elapsed cycles since scanning began, plus buffers
    bit          m_scan = 0;
    int          m_t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pend = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t tbl[6];

    bcd_sevenseg_scan #(.REFRESH_DIV(DIV), .GUARD_CYCLES(GUARD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .bcd_vld    (bcd_vld),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int d, input bit blank);
        if (blank) return 7'b1111111;
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: model predicts registered outputs, DUT sampled on the falling edge
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        int p, i, d;
        bit bl;
        @(posedge clk);
        e_an  = 4'hF;
        e_seg = 7'h7F;
        if (!rst_n) begin
            m_scan = 0; m_t = 0; m_disp = '0; m_shadow = '0; m_pend = 0;
        end else if (m_scan) begin
            p = m_t % DIV;
            i = (m_t / DIV) % 4;
            if (p >= GUARD) begin
                d  = int'((m_disp >> (4 * i)) & 16'hF);
                bl = 0;
`ifdef LEADING_ZERO_BLANK_EN
                bl = (i > 0) && ((m_disp >> (4 * i)) == 16'h0);
`endif
                e_an  = ~(4'b0001 << i);
                e_seg = ref_seg(d, bl);
            end
            if (m_t % FRAME == FRAME - 1) begin
                if (bcd_vld) begin
                    m_disp = bcd_in; m_pend = 0;
                end else if (m_pend) begin
                    m_disp = m_shadow; m_pend = 0;
                end
            end else if (bcd_vld) begin
                m_shadow = bcd_in; m_pend = 1;
            end
            m_t++;
        end else if (bcd_vld) begin
            m_scan = 1; m_t = 0; m_disp = bcd_in;
        end
        @(negedge clk);
        chk("an", 32'(an), 32'(e_an));
        if (e_an != 4'hF) chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_tick", 32'(frame_tick), 32'(m_scan && (m_t % FRAME == FRAME - 1)));
        chk("dp", 32'(dp), 32'd1);
        bcd_vld = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] v);
        bcd_in  = v;
        bcd_vld = 1'b1;
        step();
    endtask

    task automatic wait_ft();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 2 * FRAME) begin
            step();
            n++;
        end
        chk("frame_tick_timeout", 32'(n < 2 * FRAME), 32'd1);
    endtask

    // run 33 cycles from a frame edge, keeping the last pattern seen on each digit
    task automatic capture(output logic [27:0] segs);
        segs = '1;
        for (int k = 0; k < FRAME + 1; k++) begin
            step();
            case (an)
                4'b1110: segs[6:0]   = seg;
                4'b1101: segs[13:7]  = seg;
                4'b1011: segs[20:14] = seg;
                4'b0111: segs[27:21] = seg;
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [27:0] got;

        tbl[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        tbl[4] = '{16'h4095, {7'b0011001, 7'b1000000, 7'b0010000, 7'b0010010}};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[1] = '{16'h0567, {7'b1111111, 7'b0010010, 7'b0000010, 7'b1111000}};
        tbl[2] = '{16'h00A0, {7'b1111111, 7'b1111111, 7'b0111111, 7'b1000000}};
        tbl[3] = '{16'h0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        tbl[5] = '{16'h0002, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}};
`else
        tbl[1] = '{16'h0567, {7'b1000000, 7'b0010010, 7'b0000010, 7'b1111000}};
        tbl[2] = '{16'h00A0, {7'b1000000, 7'b1000000, 7'b0111111, 7'b1000000}};
        tbl[3] = '{16'h0000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
        tbl[5] = '{16'h0002, {7'b1000000, 7'b1000000, 7'b1000000, 7'b0100100}};
`endif

        repeat (3) @(negedge clk);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_ft", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;

        // idle: no data yet, display dark and no frame ticks
        for (int k = 0; k < 100; k++) step();

        // table vectors: load, let it commit at a frame edge, capture the next frame
        for (int v = 0; v < 4; v++) begin
            repeat (5) step();
            pulse(tbl[v].bcd);
            wait_ft();
            capture(got);
            chk($sformatf("frame_%04h", tbl[v].bcd), 32'(got), 32'(tbl[v].segs));
        end

        // strobe on the exact frame edge overrides an older pending value
        repeat (3) step();
        pulse(16'h1234);
        wait_ft();
        pulse(16'h4095);
        capture(got);
        chk("edge_capture", 32'(got), 32'(tbl[4].segs));
        wait_ft();
        capture(got);
        chk("no_carryover", 32'(got), 32'(tbl[4].segs));

        // two strobes in one frame: the later one wins
        repeat (3) step();
        pulse(16'h0001);
        repeat (4) step();
        pulse(16'h0002);
        wait_ft();
        capture(got);
        chk("last_wins", 32'(got), 32'(tbl[5].segs));

        // random strobes checked cycle-by-cycle against the model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                bcd_in  = 16'($urandom());
                bcd_vld = 1'b1;
            end
            step();
        end

        // asynchronous reset in the middle of slot 2
        begin
            int n = 0;
            while (!(m_scan && ((m_t / DIV) % 4 == 2) && (m_t % DIV == 4)) && n < 2 * FRAME) begin
                step();
                n++;
            end
            chk("slot2_timeout", 32'(n < 2 * FRAME), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_ft", 32'(frame_tick), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) step();
        pulse(16'h0567);
        wait_ft();
        capture(got);
        chk("after_reset", 32'(got), 32'(tbl[1].segs));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
